// File: rtl/shk_ctrl_slave.sv
// -----------------------------------------------------------------------------
// shk_ctrl_slave
//   Responder end of the shk_ctrl four-phase handshake. A master raises wvalid
//   with a command word (smosi) and a data word (dmosi). The request must stay
//   stable for SETL_CYC cycles. The block then performs one register write or
//   read, presents the status on smiso and the data on dmiso, and holds wready
//   until the master drops wvalid.
//
//   Ports
//     s_sys_base_clock   : clock, all logic on the rising edge
//     s_sys_base_reset   : synchronous active-high reset
//     s_shk_ctrl_wvalid  : master request level
//     s_shk_ctrl_smosi   : command {op, reserved, addr}; op=1 write, op=0 read
//     s_shk_ctrl_dmosi   : write data
//     s_shk_ctrl_wready  : response-valid level
//     s_shk_ctrl_smiso   : status {op, err, smosi[WD_SYNC-3:0]}
//     s_shk_ctrl_dmiso   : read data, or the echoed write data for a write
//     m_reg_data         : flat register bank, reg k at [k*WD_DLAY +: WD_DLAY]
//     m_reg_wstb         : high for the one execute cycle when reg k is written
// -----------------------------------------------------------------------------
module shk_ctrl_slave #(
  parameter int WD_SYNC  = 16,
  parameter int WD_DLAY  = 15,
  parameter int WD_ADDR  = 4,
  parameter int NUM_REGS = 16,
  parameter int SETL_CYC = 4
) (
  input  logic                         s_sys_base_clock,
  input  logic                         s_sys_base_reset,
  input  logic                         s_shk_ctrl_wvalid,
  input  logic [WD_SYNC-1:0]           s_shk_ctrl_smosi,
  input  logic [WD_DLAY-1:0]           s_shk_ctrl_dmosi,
  output logic                         s_shk_ctrl_wready,
  output logic [WD_SYNC-1:0]           s_shk_ctrl_smiso,
  output logic [WD_DLAY-1:0]           s_shk_ctrl_dmiso,
  output logic [NUM_REGS*WD_DLAY-1:0]  m_reg_data,
  output logic [NUM_REGS-1:0]          m_reg_wstb
);

  localparam int WD_CNT = (SETL_CYC > 1) ? $clog2(SETL_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETL, EXEC, RESP} state_t;

  state_t               state;
  logic                 r_wvalid;
  logic [WD_SYNC-1:0]   r_smosi;
  logic [WD_DLAY-1:0]   r_dmosi;
  logic [WD_SYNC-1:0]   cap_smosi;
  logic [WD_DLAY-1:0]   cap_dmosi;
  logic [WD_CNT-1:0]    cnt;
  logic                 armed;
  logic [WD_DLAY-1:0]   regs [NUM_REGS];

  // Address decode of the captured command. An address with no matching
  // register is an error, so err falls out of the one-hot hit vector.
  logic                 cap_op;
  logic [WD_ADDR-1:0]   cap_addr;
  logic [NUM_REGS-1:0]  hit;
  logic                 cap_err;
  logic [WD_DLAY-1:0]   rd_data;

  assign cap_op   = cap_smosi[WD_SYNC-1];
  assign cap_addr = cap_smosi[WD_ADDR-1:0];
  assign cap_err  = ~|hit;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit     = '0;
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      hit[k] = (cap_addr == WD_ADDR'(k));
      if (hit[k]) rd_data = regs[k];
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign m_reg_data[k*WD_DLAY +: WD_DLAY] = regs[k];
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge s_sys_base_clock) begin
    if (s_sys_base_reset) begin
      // The sampled request resets to "busy": a wvalid held through reset
      // must be seen low before the block re-arms.
      r_wvalid          <= 1'b1;
      r_smosi           <= '0;
      r_dmosi           <= '0;
      state             <= IDLE;
      cnt               <= '0;
      armed             <= 1'b0;
      cap_smosi         <= '0;
      cap_dmosi         <= '0;
      s_shk_ctrl_wready <= 1'b0;
      s_shk_ctrl_smiso  <= '0;
      s_shk_ctrl_dmiso  <= '0;
      m_reg_wstb        <= '0;
      // NOTE: the register bank is software-visible state with defined
      // post-reset contents, so it is built from resettable flops, not RAM.
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      r_wvalid   <= s_shk_ctrl_wvalid;
      r_smosi    <= s_shk_ctrl_smosi;
      r_dmosi    <= s_shk_ctrl_dmosi;
      m_reg_wstb <= '0;

      if (!r_wvalid) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (r_wvalid && armed) begin
            state     <= SETL;
            cnt       <= '0;
            cap_smosi <= r_smosi;
            cap_dmosi <= r_dmosi;
            armed     <= 1'b0;
          end
        end

        SETL: begin
          if (!r_wvalid) begin
            state <= IDLE;
          end else if (r_smosi != cap_smosi || r_dmosi != cap_dmosi) begin
            cap_smosi <= r_smosi;
            cap_dmosi <= r_dmosi;
            cnt       <= '0;
          end else if (cnt == WD_CNT'(SETL_CYC - 1)) begin
            state <= EXEC;
            // Strobe is registered here so it is high during the execute cycle.
            m_reg_wstb <= cap_op ? hit : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        EXEC: begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (cap_op && hit[k]) regs[k] <= cap_dmosi;
          end
          s_shk_ctrl_smiso  <= {cap_op, cap_err, cap_smosi[WD_SYNC-3:0]};
          // rd_data is already zero for an unmapped address.
          s_shk_ctrl_dmiso  <= cap_op ? cap_dmosi : rd_data;
          s_shk_ctrl_wready <= 1'b1;
          state             <= RESP;
        end

        RESP: begin
          if (!r_wvalid) begin
            s_shk_ctrl_wready <= 1'b0;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shk_ctrl_slave.md
Name: shk_ctrl_slave

Overview:
- Responder (slave) end of the shk_ctrl four-phase handshake.
- A master raises wvalid with a command word (smosi) and a data word (dmosi). This block debounces the request, executes a register write or read, answers on smiso/dmiso, and holds wready until the master drops wvalid.
- It provides a small software-visible register bank in the PL. Each register is exported as a flat bus, and each has a one-cycle write strobe.

Parameters:
- WD_SYNC, 16, width of smosi/smiso command/status words (min WD_ADDR+2).
- WD_DLAY, 15, width of dmosi/dmiso data words and of each register.
- WD_ADDR, 4, address field width inside smosi.
- NUM_REGS, 16, number of registers implemented (1..2^WD_ADDR).
- SETL_CYC, 4, cycles that wvalid/smosi/dmosi must stay stable before acceptance (>=1).

Ports:
- s_sys_base_clock, in, 1, single clock; all logic on its rising edge.
- s_sys_base_reset, in, 1, synchronous, active-high reset.
- s_shk_ctrl_wvalid, in, 1, master request level.
- s_shk_ctrl_smosi, in, WD_SYNC, command: [WD_SYNC-1]=op (1 write, 0 read), [WD_ADDR-1:0]=address, other bits reserved and echoed.
- s_shk_ctrl_dmosi, in, WD_DLAY, write data.
- s_shk_ctrl_wready, out, 1, response-valid level.
- s_shk_ctrl_smiso, out, WD_SYNC, status: [WD_SYNC-1]=op echo, [WD_SYNC-2]=err, [WD_SYNC-3:0]=smosi[WD_SYNC-3:0] echo.
- s_shk_ctrl_dmiso, out, WD_DLAY, read data (write: echoes the written data).
- m_reg_data, out, NUM_REGS*WD_DLAY, register contents; reg k occupies bits [k*WD_DLAY +: WD_DLAY].
- m_reg_wstb, out, NUM_REGS, one-cycle pulse on bit k when reg k is written.

Behaviour:
- Input stage: wvalid/smosi/dmosi are registered once (r_*); the FSM uses only the registered copies.
- Reset: all outputs are 0, every register is 0, FSM goes to IDLE, the settle counter is 0, and the arm flag is cleared.
- Arm flag:
  - Set when r_wvalid==0 is seen.
  - IDLE accepts a request only when the flag is set.
  - Consequence: a wvalid held high across a reset is never re-executed.
- FSM states:
  - IDLE: on r_wvalid=1 && armed, go to SETL with cnt=0 and capture r_smosi/r_dmosi.
  - SETL:
    - r_wvalid=0 → IDLE.
    - r_smosi or r_dmosi differs from the captured value → recapture and set cnt=0.
    - Otherwise cnt++; when cnt==SETL_CYC-1, go to EXEC.
  - EXEC (1 cycle):
    - Decode address; err = (addr >= NUM_REGS).
    - Write with !err: register ← captured dmosi, and m_reg_wstb[addr] pulses in this cycle.
    - Write with err: no register change and no strobe.
    - Load smiso per the format above.
    - dmiso = written data (write), reg[addr] (read, !err), or 0 (read, err).
    - Go to RESP.
  - RESP: wready=1. When r_wvalid==0: wready=0 on the next edge, clear arm flag handling as normal, return to IDLE.
- Latency: with stable inputs, wready rises SETL_CYC+3 cycles after the first cycle wvalid is high at the port (7 for the default).
- smiso/dmiso change only in EXEC. They hold their value after wready falls, until the next EXEC.
- Register updates are visible on m_reg_data the cycle after EXEC.
- Read-after-write to the same address in consecutive transactions returns the new value.
- Reserved smosi bits do not affect decoding; they are echoed only.
- Reset mid-transaction (any state): wready=0 at the next edge, no partial write occurs, and the current transaction is abandoned.
- In RESP, changes to smosi/dmosi while wvalid stays high are ignored.

Test Plan:
- Reset, then write: smosi=0x8003, dmosi=0x1234, wvalid=1 → wready=1 after 7 cycles; smiso=0x8003; dmiso=0x1234; m_reg_wstb=0x0008 pulse one cycle; reg3=0x1234. Drop wvalid → wready=0 two cycles later.
- Read back: smosi=0x0003 → smiso=0x0003, dmiso=0x1234, no wstb. Read of unwritten reg5 → dmiso=0.
- Error address, NUM_REGS=8: write smosi=0x800A, dmosi=0x7FFF → smiso=0xC00A (err set), no strobe, all registers unchanged. Read of 0x000A → smiso=0x400A, dmiso=0.
- Glitch/settle: wvalid high for 3 cycles then low → no wready, no write. dmosi changed at cycle 2 of SETL → wready delayed by 3 cycles and the new dmosi is written.
- Reset while in RESP with wvalid held high → wready=0. After reset release, no re-execution until wvalid goes low then high again; the retry completes normally.
- Back-to-back: 16 writes to addresses 0..15 with data 0x100+k, then 16 reads → each dmiso=0x100+k, and m_reg_data matches.
